// File: rtl/cpu_multicycle_control.sv
// Multi-cycle CPU control: sequences FETCH/DECODE/EXEC/MEM/WB, with memory timeout,
// maskable interrupt and undefined-instruction traps. Outputs are decoded from state.
module cpu_multicycle_control #(
    parameter int NUM_IRQ     = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         Funct,
    input  logic               pchigh,
    input  logic               branch_taken,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               mem_ready,
    output logic [2:0]         state,
    output logic               PCWr,
    output logic               IRWr,
    output logic               MemRd,
    output logic               MemWr,
    output logic               RegWr,
    output logic [2:0]         PCSrc,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemToReg,
    output logic               EPCWr,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [2:0]         exc_code
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(MEM_TIMEOUT - 1);

    // state  | meaning
    // FETCH  | instruction read, waits on mem_ready
    // DECODE | irq / undefined check
    // EXEC   | branch/jump resolve, ALU op
    // MEM    | lw/sw access, waits on mem_ready
    // WB     | register write
    // TRAP   | EPC save, vector to handler
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         exc_q, exc_d;
    logic [NUM_IRQ-1:0] ack_q, ack_d;

    logic               r_ok, defined, is_branch, is_j, is_jal, is_jr, is_jalr, is_lw, is_sw;
    logic [NUM_IRQ-1:0] pend, pend_low;
    logic               found, timeout;

    always_comb begin
        r_ok      = (opcode == 6'h00) &&
                    (Funct inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09, [6'h20:6'h27], 6'h2A, 6'h2B});
        defined   = r_ok || (opcode inside {[6'h01:6'h0D], 6'h0F, 6'h23, 6'h2B});
        is_branch = opcode inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07};
        is_j      = (opcode == 6'h02);
        is_jal    = (opcode == 6'h03);
        is_jr     = r_ok && (Funct == 6'h08);
        is_jalr   = r_ok && (Funct == 6'h09);
        is_lw     = (opcode == 6'h23);
        is_sw     = (opcode == 6'h2B);
        timeout   = (cnt_q == TO_LAST);
    end

    // lowest-index pending line wins the acknowledge
    always_comb begin
        pend     = irq & irq_mask;
        pend_low = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (pend[i] && !found) begin
                pend_low[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        exc_d   = exc_q;
        ack_d   = ack_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    exc_d   = 3'd3;
                end
            end
            S_DECODE: begin
                if ((pend != '0) && !pchigh) begin
                    state_d = S_TRAP;
                    exc_d   = 3'd1;
                    ack_d   = pend_low;
                end else if (!defined) begin
                    if (!pchigh) begin
                        state_d = S_TRAP;
                        exc_d   = 3'd2;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_lw || is_sw)                  state_d = S_MEM;
                else if (is_branch || is_j || is_jr) state_d = S_FETCH;
                else                                 state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = is_lw ? S_WB : S_FETCH;
                end else if (timeout) begin
                    state_d = S_TRAP;
                    exc_d   = 3'd3;
                end
            end
            default: state_d = S_FETCH;
        endcase
        // counter only runs while waiting in an access state; any transition clears it
        cnt_d = ((state_q == S_FETCH || state_q == S_MEM) && state_d == state_q)
                ? cnt_q + CW'(1) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            exc_q   <= 3'd0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exc_q   <= exc_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        MemRd    = 1'b0;
        MemWr    = 1'b0;
        RegWr    = 1'b0;
        PCSrc    = 3'd0;
        RegDst   = 2'd0;
        MemToReg = 2'd0;
        EPCWr    = 1'b0;
        irq_ack  = '0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRd = 1'b1;
                    if (mem_ready) begin
                        IRWr = 1'b1;
                        PCWr = 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_branch && branch_taken) begin
                        PCWr  = 1'b1;
                        PCSrc = 3'd1;
                    end else if (is_j || is_jal) begin
                        PCWr  = 1'b1;
                        PCSrc = 3'd2;
                    end else if (is_jr || is_jalr) begin
                        PCWr  = 1'b1;
                        PCSrc = 3'd3;
                    end
                end
                S_MEM: begin
                    MemRd = is_lw;
                    MemWr = is_sw;
                end
                S_WB: begin
                    RegWr = 1'b1;
                    if (is_jal) begin
                        RegDst   = 2'd2;
                        MemToReg = 2'd2;
                    end else if (is_jalr) begin
                        MemToReg = 2'd2;
                    end else if (is_lw) begin
                        RegDst   = 2'd1;
                        MemToReg = 2'd1;
                    end else if (opcode != 6'h00) begin
                        RegDst   = 2'd1;
                    end
                end
                S_TRAP: begin
                    EPCWr    = 1'b1;
                    PCWr     = 1'b1;
                    RegWr    = 1'b1;
                    RegDst   = 2'd3;
                    MemToReg = 2'd2;
                    PCSrc    = (exc_q == 3'd1) ? 3'd4 : 3'd5;
                    irq_ack  = (exc_q == 3'd1) ? ack_q : '0;
                end
                default: ;
            endcase
        end
    end

    assign state    = state_q;
    assign exc_code = reset ? exc_q : 3'd0;

endmodule

// File: tb/tb_cpu_multicycle_control.sv
// Bench for cpu_multicycle_control: each instruction is expanded by a per-instruction
// reference model into an expected cycle trace, then replayed against the DUT.
module tb_cpu_multicycle_control;

    localparam int NI = 4;
    localparam int MT = 15;
    localparam int VW = 19 + NI;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    opcode, Funct;
    logic          pchigh, branch_taken, mem_ready;
    logic [NI-1:0] irq, irq_mask;
    logic [2:0]    state, PCSrc, exc_code;
    logic          PCWr, IRWr, MemRd, MemWr, RegWr, EPCWr;
    logic [1:0]    RegDst, MemToReg;
    logic [NI-1:0] irq_ack;

    always #5 clk = ~clk;

    cpu_multicycle_control #(.NUM_IRQ(NI), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .Funct(Funct), .pchigh(pchigh),
        .branch_taken(branch_taken), .irq(irq), .irq_mask(irq_mask), .mem_ready(mem_ready),
        .state(state), .PCWr(PCWr), .IRWr(IRWr), .MemRd(MemRd), .MemWr(MemWr), .RegWr(RegWr),
        .PCSrc(PCSrc), .RegDst(RegDst), .MemToReg(MemToReg), .EPCWr(EPCWr),
        .irq_ack(irq_ack), .exc_code(exc_code)
    );

    typedef struct {
        logic          mr;
        logic [2:0]    st;
        logic          pcwr, irwr, memrd, memwr, regwr;
        logic [2:0]    pcsrc;
        logic [1:0]    regdst, m2r;
        logic          epcwr;
        logic [NI-1:0] ack;
        logic [2:0]    exc;
    } cyc_t;

    cyc_t          tr[$];
    logic [2:0]    exp_exc;
    int            nvec = 0;
    int            nerr = 0;
    logic [5:0]    nx_op, nx_fn;
    logic          nx_ph, nx_bt;
    logic [NI-1:0] nx_iq, nx_mk;

    function automatic cyc_t blank(input logic [2:0] st, input logic mr);
        cyc_t c;
        c.mr = mr; c.st = st;
        c.pcwr = 0; c.irwr = 0; c.memrd = 0; c.memwr = 0; c.regwr = 0;
        c.pcsrc = 0; c.regdst = 0; c.m2r = 0; c.epcwr = 0; c.ack = '0;
        c.exc = exp_exc;
        return c;
    endfunction

    function automatic void push_trap(input logic [NI-1:0] a);
        cyc_t c;
        c = blank(3'd5, 1'b0);
        c.epcwr = 1; c.pcwr = 1; c.regwr = 1; c.regdst = 2'd3; c.m2r = 2'd2;
        c.pcsrc = (exp_exc == 3'd1) ? 3'd4 : 3'd5;
        c.ack   = (exp_exc == 3'd1) ? a : '0;
        tr.push_back(c);
    endfunction

    // Expected trace for one instruction; fd/md = wait cycles before mem_ready in FETCH/MEM.
    function automatic void build(input logic [5:0] op, input logic [5:0] fn, input logic ph,
                                  input logic bt, input logic [NI-1:0] iq, input logic [NI-1:0] mk,
                                  input int fd, input int md);
        cyc_t c;
        logic [NI-1:0] p, a;
        bit rok, def, isb, isj, isjal, isjr, isjalr, islw, issw;
        int lo;
        tr.delete();
        nx_op = op; nx_fn = fn; nx_ph = ph; nx_bt = bt; nx_iq = iq; nx_mk = mk;
        rok    = (op == 0) && (fn inside {0, 2, 3, 8, 9, [32:39], 42, 43});
        def    = rok || (op inside {[1:13], 15, 35, 43});
        isb    = op inside {1, 4, 5, 6, 7};
        isj    = (op == 2);
        isjal  = (op == 3);
        isjr   = rok && (fn == 8);
        isjalr = rok && (fn == 9);
        islw   = (op == 35);
        issw   = (op == 43);
        for (int i = 0; i < MT; i++) begin
            c = blank(3'd0, i == fd);
            c.memrd = 1;
            if (i == fd) begin
                c.irwr = 1; c.pcwr = 1;
                tr.push_back(c);
                break;
            end
            tr.push_back(c);
            if (i == MT - 1) begin
                exp_exc = 3'd3;
                push_trap('0);
                return;
            end
        end
        tr.push_back(blank(3'd1, 1'b0));
        p = iq & mk;
        if (p != '0 && !ph) begin
            lo = 0;
            for (int k = NI - 1; k >= 0; k--) if (p[k]) lo = k;
            a = '0;
            a[lo] = 1'b1;
            exp_exc = 3'd1;
            push_trap(a);
            return;
        end
        if (!def) begin
            if (!ph) begin
                exp_exc = 3'd2;
                push_trap('0);
            end
            return;
        end
        c = blank(3'd2, 1'b0);
        if (isb) begin
            c.pcwr = bt; c.pcsrc = bt ? 3'd1 : 3'd0;
        end else if (isj || isjal) begin
            c.pcwr = 1; c.pcsrc = 3'd2;
        end else if (isjr || isjalr) begin
            c.pcwr = 1; c.pcsrc = 3'd3;
        end
        tr.push_back(c);
        if (isb || isj || isjr) return;
        if (islw || issw) begin
            for (int i = 0; i < MT; i++) begin
                c = blank(3'd3, i == md);
                c.memrd = islw; c.memwr = issw;
                tr.push_back(c);
                if (i == md) break;
                if (i == MT - 1) begin
                    exp_exc = 3'd3;
                    push_trap('0);
                    return;
                end
            end
            if (issw) return;
        end
        c = blank(3'd4, 1'b0);
        c.regwr = 1;
        if (isjal) begin
            c.regdst = 2'd2; c.m2r = 2'd2;
        end else if (isjalr) begin
            c.m2r = 2'd2;
        end else if (islw) begin
            c.regdst = 2'd1; c.m2r = 2'd1;
        end else if (op != 0) begin
            c.regdst = 2'd1;
        end
        tr.push_back(c);
    endfunction

    function automatic logic [VW-1:0] pack(input cyc_t c);
        return {c.st, c.pcwr, c.irwr, c.memrd, c.memwr, c.regwr, c.pcsrc,
                c.regdst, c.m2r, c.epcwr, c.ack, c.exc};
    endfunction

    function automatic logic [VW-1:0] obs();
        return {state, PCWr, IRWr, MemRd, MemWr, RegWr, PCSrc,
                RegDst, MemToReg, EPCWr, irq_ack, exc_code};
    endfunction

    task automatic apply_instr();
        opcode = nx_op; Funct = nx_fn; pchigh = nx_ph; branch_taken = nx_bt;
        irq = nx_iq; irq_mask = nx_mk;
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_ready = 1'b1; opcode = 6'h00; Funct = 6'h20;
        pchigh = 1'b0; branch_taken = 1'b1; irq = '1; irq_mask = '1;
        exp_exc = 3'd0;
        repeat (2) @(negedge clk);
        #1;
        nvec++;
        if (obs() !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: got %h exp %h", obs(), {VW{1'b0}});
        end
        mem_ready = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic test_directed();
        logic [5:0] ops[9]  = '{6'h00, 6'h23, 6'h00, 6'h00, 6'h3F, 6'h3F, 6'h00, 6'h00, 6'h2B};
        logic [5:0] fns[9]  = '{6'h20, 6'h00, 6'h20, 6'h20, 6'h00, 6'h00, 6'h21, 6'h22, 6'h00};
        logic       phs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        int         fds[9]  = '{0, 0, 0, 0, 0, 0, MT, MT - 1, 0};
        int         mds[9]  = '{0, 3, 0, 0, 0, 0, 0, 0, MT + 2};
        for (int t = 0; t < 9; t++) begin
            build(ops[t], fns[t], phs[t], 1'b0, (t == 2 || t == 3) ? 4'b0110 : 4'b0000,
                  (t == 2 || t == 3) ? 4'b0100 : 4'b0000, fds[t], mds[t]);
            foreach (tr[i]) begin
                @(negedge clk);
                if (i == 0) apply_instr();
                mem_ready = tr[i].mr;
                #1;
                nvec++;
                if (obs() !== pack(tr[i])) begin
                    nerr++;
                    $display("FAIL directed t%0d cyc%0d: got %h exp %h", t, i, obs(), pack(tr[i]));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[10] = '{6'h03, 6'h00, 6'h02, 6'h00, 6'h04, 6'h05, 6'h23, 6'h09, 6'h0F, 6'h00};
        logic [5:0] fns[10] = '{6'h00, 6'h09, 6'h00, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h2A};
        logic       bts[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int t = 0; t < 10; t++) begin
            build(ops[t], fns[t], 1'b0, bts[t], '0, '0, 0, 0);
            foreach (tr[i]) begin
                @(negedge clk);
                if (i == 0) apply_instr();
                mem_ready = tr[i].mr;
                #1;
                nvec++;
                if (obs() !== pack(tr[i])) begin
                    nerr++;
                    $display("FAIL b2b t%0d cyc%0d: got %h exp %h", t, i, obs(), pack(tr[i]));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] op_pool[20] = '{0, 0, 0, 1, 2, 3, 4, 5, 8, 9, 12, 13, 15, 35, 35, 43, 43, 14, 63, 16};
        logic [5:0] fn_pool[15] = '{0, 2, 3, 8, 9, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
        logic [5:0] op, fn;
        logic [NI-1:0] iq, mk;
        int fd, md;
        for (int t = 0; t < 80; t++) begin
            op = op_pool[$urandom_range(0, 19)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 14)];
            iq = NI'($urandom);
            mk = ($urandom_range(0, 2) == 0) ? NI'($urandom) : '0;
            fd = ($urandom_range(0, 9) == 0) ? MT - 1 + $urandom_range(0, 2) : $urandom_range(0, 3);
            md = ($urandom_range(0, 9) == 0) ? MT - 1 + $urandom_range(0, 2) : $urandom_range(0, 3);
            build(op, fn, ($urandom_range(0, 3) == 0), 1'($urandom), iq, mk, fd, md);
            foreach (tr[i]) begin
                @(negedge clk);
                if (i == 0) apply_instr();
                mem_ready = tr[i].mr;
                #1;
                nvec++;
                if (obs() !== pack(tr[i])) begin
                    nerr++;
                    $display("FAIL random t%0d op%h fn%h cyc%0d: got %h exp %h",
                             t, op, fn, i, obs(), pack(tr[i]));
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        // leave a nonzero exc_code behind so the reset clearing it is visible
        build(6'h3F, 6'h00, 1'b0, 1'b0, '0, '0, 0, 0);
        foreach (tr[i]) begin
            @(negedge clk);
            if (i == 0) apply_instr();
            mem_ready = tr[i].mr;
            #1;
            nvec++;
            if (obs() !== pack(tr[i])) begin
                nerr++;
                $display("FAIL rst_pre cyc%0d: got %h exp %h", i, obs(), pack(tr[i]));
            end
        end
        build(6'h2B, 6'h00, 1'b0, 1'b0, '0, '0, 0, 5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) apply_instr();
            mem_ready = tr[i].mr;
            #1;
            nvec++;
            if (obs() !== pack(tr[i])) begin
                nerr++;
                $display("FAIL rst_sw cyc%0d: got %h exp %h", i, obs(), pack(tr[i]));
            end
        end
        #1 reset = 1'b0;
        #1;
        nvec++;
        if (obs() !== '0) begin
            nerr++;
            $display("FAIL rst_mid_mem: got %h exp %h", obs(), {VW{1'b0}});
        end
        exp_exc = 3'd0;
        @(posedge clk);
        #2 reset = 1'b1;
        build(6'h00, 6'h20, 1'b0, 1'b0, '0, '0, 1, 0);
        foreach (tr[i]) begin
            @(negedge clk);
            if (i == 0) apply_instr();
            mem_ready = tr[i].mr;
            #1;
            nvec++;
            if (obs() !== pack(tr[i])) begin
                nerr++;
                $display("FAIL rst_after cyc%0d: got %h exp %h", i, obs(), pack(tr[i]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/cpu_multicycle_control.md
Name: cpu_multicycle_control

Overview:
- Multi-cycle successor to the single-cycle CPU control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath enables and mux selects per phase.
- Handles a memory ready handshake with a timeout-to-trap, NUM_IRQ maskable interrupt lines with a one-hot acknowledge, and an undefined-instruction trap.
- Sits between the instruction register/memory interface and the existing datapath (register file, ALU, PC mux).

Parameters:
NUM_IRQ, 4, number of interrupt request lines (1..16)
MEM_TIMEOUT, 15, cycles without mem_ready in FETCH/MEM before a bus-timeout trap (>=1); counter width ceil(log2(MEM_TIMEOUT+1))

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], stable from DECODE until the next IRWr
Funct  in  6  IR[5:0]
pchigh  in  1  PC[31]; 1 = kernel mode
branch_taken  in  1  ALU branch condition, valid in EXEC
irq  in  NUM_IRQ  level interrupt requests
irq_mask  in  NUM_IRQ  1 = line enabled
mem_ready  in  1  memory completes the current access this cycle
state  out  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 TRAP
PCWr  out  1  PC write enable
IRWr  out  1  IR write enable
MemRd  out  1  memory read request
MemWr  out  1  memory write request
RegWr  out  1  register file write enable
PCSrc  out  3  000 PC+4, 001 branch target, 010 jump target, 011 register (jr/jalr), 100 interrupt vector, 101 exception vector
RegDst  out  2  00 rd, 01 rt, 10 $31, 11 $26
MemToReg  out  2  00 ALU, 01 memory, 10 PC+4
EPCWr  out  1  EPC write enable
irq_ack  out  NUM_IRQ  one-hot acknowledge, 1-cycle pulse in TRAP
exc_code  out  3  0 none, 1 interrupt, 2 undefined instruction, 3 bus timeout

Behaviour:
- Reset (reset=0, async): state=FETCH, timeout counter=0, exc_code=0. While reset is low, all outputs other than state are forced to 0.
- Outputs are combinational from state, opcode, Funct, mem_ready and branch_taken. Any output not listed for a state is 0.
- Supported instructions:
  - opcode 0 with Funct in {0,2,3,8,9,20h-27h,2Ah,2Bh}
  - opcodes {1-9,Ah,Bh,Ch,Dh,Fh,23h,2Bh}
  - anything else is undefined.
- FETCH: MemRd=1.
  - mem_ready=1: IRWr=1, PCWr=1, PCSrc=000, counter cleared -> DECODE.
  - Otherwise the counter increments; at counter==MEM_TIMEOUT-1 with no mem_ready -> TRAP, exc_code=3.
  - mem_ready in the same cycle as the timeout wins.
- DECODE: evaluate in priority order.
  1. pending=(irq & irq_mask)!=0 and pchigh=0 -> TRAP, exc_code=1, lowest-index pending line latched for irq_ack.
  2. Undefined instruction and pchigh=0 -> TRAP, exc_code=2.
  3. Undefined instruction and pchigh=1 -> FETCH (executed as nop).
  4. Otherwise -> EXEC.
- Interrupts are level-sensitive and sampled only in DECODE; they are not latched in other states.
- EXEC:
  - Branches (op 1,4-7): if branch_taken then PCWr=1, PCSrc=001. -> FETCH.
  - j: PCWr=1, PCSrc=010 -> FETCH.
  - jal: PCWr=1, PCSrc=010 -> WB.
  - jr: PCWr=1, PCSrc=011 -> FETCH.
  - jalr: PCWr=1, PCSrc=011 -> WB.
  - lw/sw -> MEM.
  - All other ALU ops -> WB.
- MEM: lw drives MemRd=1, sw drives MemWr=1, held until mem_ready.
  - Timeout rules as in FETCH, with the counter cleared on MEM entry.
  - On mem_ready: lw -> WB, sw -> FETCH.
- WB: RegWr=1 for one cycle -> FETCH. Selects by instruction:
  - R-type: RegDst=00, MemToReg=00.
  - I-type ALU: RegDst=01, MemToReg=00.
  - lw: RegDst=01, MemToReg=01.
  - jal: RegDst=10, MemToReg=10.
  - jalr: RegDst=00, MemToReg=10.
- TRAP: one cycle -> FETCH.
  - Drives EPCWr=1, PCWr=1, RegWr=1, RegDst=11, MemToReg=10.
  - PCSrc=100 if exc_code=1, else 101.
  - irq_ack=one-hot of the latched line, only when exc_code=1.
- exc_code is registered on TRAP entry and holds until the next trap entry or reset.
- No state other than FETCH, MEM or TRAP lasts more than one cycle. Unused encodings 6/7 -> FETCH.
- Reset asserted mid-access drops MemRd/MemWr immediately; FETCH restarts after release.

Test Plan:
- add (op 0, Funct 20h), mem_ready=1 in FETCH -> states 0,1,2,4,0; RegWr=1 in WB with RegDst=00; 5 cycles total.
- lw with mem_ready delayed 3 cycles in MEM -> MemRd held 4 cycles; WB shows RegDst=01, MemToReg=01.
- irq=0110, irq_mask=0100, pchigh=0 at DECODE -> TRAP, irq_ack=0100, exc_code=1, PCSrc=100, RegDst=11; same stimulus with pchigh=1 -> EXEC, no ack.
- opcode 3Fh, pchigh=0 -> TRAP with exc_code=2, PCSrc=101; pchigh=1 -> DECODE->FETCH with RegWr never asserted.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> TRAP on the 15th cycle, exc_code=3; a mem_ready pulse on the 15th cycle -> DECODE instead.
- Drop reset during MEM of sw -> MemWr=0 the same cycle; after release state=FETCH, exc_code=0.
